// File: rtl/ldb_cmd_queue_pkg.sv
// Shared types for the LDB command queue: command record, issue FSM states,
// field widths and the command legality rule.
package ldb_pkg;

    localparam int unsigned LDB_SMC_CNT   = 4;
    localparam int unsigned SMC_STRB_W    = 6;
    localparam int unsigned BYTE_STRB_W   = 4;
    localparam int unsigned BRST_W        = 16;
    localparam int unsigned GR_ADDR_W     = 32;
    localparam int unsigned LDB_SMC_ID_W  = $clog2(LDB_SMC_CNT);
    localparam int unsigned UR_ID_W       = 8;
    localparam int unsigned UR_ADDR_W     = 16;
    localparam int unsigned DROP_CNT_W    = 8;

    typedef struct packed {
        logic [SMC_STRB_W-1:0]   smc_strb;
        logic [BYTE_STRB_W-1:0]  byte_strb;
        logic [BRST_W-1:0]       brst;
        logic [GR_ADDR_W-1:0]    gr_base_addr;
        logic [LDB_SMC_ID_W-1:0] smc_id;
        logic [UR_ID_W-1:0]      ur_id;
        logic [UR_ADDR_W-1:0]    ur_addr;
    } ldb_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DONE,
        DRAIN
    } ldb_state_t;

    // A command must move at least one beat from a word-aligned address.
    function automatic logic cmd_legal(input ldb_cmd_t c);
        return (c.brst != '0) && (c.gr_base_addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ldb_cmd_queue_if.sv
// Dispatcher-side command handshake and engine-side issue bus of the LDB queue.
// slave = queue view, master = dispatcher/engine view.
interface ldb_cmd_queue_if import ldb_pkg::*; #(
    parameter int unsigned SMC_ID_W = LDB_SMC_ID_W
);
    logic                   cmd_vld;
    logic                   cmd_rdy;
    logic [SMC_STRB_W-1:0]  cmd_smc_strb;
    logic [BYTE_STRB_W-1:0] cmd_byte_strb;
    logic [BRST_W-1:0]      cmd_brst;
    logic [GR_ADDR_W-1:0]   cmd_gr_base_addr;
    logic [SMC_ID_W-1:0]    cmd_smc_id;
    logic [UR_ID_W-1:0]     cmd_ur_id;
    logic [UR_ADDR_W-1:0]   cmd_ur_addr;

    logic                   eng_vld;
    logic [SMC_STRB_W-1:0]  eng_smc_strb;
    logic [BYTE_STRB_W-1:0] eng_byte_strb;
    logic [BRST_W-1:0]      eng_brst;
    logic [GR_ADDR_W-1:0]   eng_gr_base_addr;
    logic [SMC_ID_W-1:0]    eng_smc_id;
    logic [UR_ID_W-1:0]     eng_ur_id;
    logic [UR_ADDR_W-1:0]   eng_ur_addr;
    logic                   eng_done;

    modport slave (
        input  cmd_vld, cmd_smc_strb, cmd_byte_strb, cmd_brst, cmd_gr_base_addr,
               cmd_smc_id, cmd_ur_id, cmd_ur_addr, eng_done,
        output cmd_rdy, eng_vld, eng_smc_strb, eng_byte_strb, eng_brst,
               eng_gr_base_addr, eng_smc_id, eng_ur_id, eng_ur_addr
    );

    modport master (
        output cmd_vld, cmd_smc_strb, cmd_byte_strb, cmd_brst, cmd_gr_base_addr,
               cmd_smc_id, cmd_ur_id, cmd_ur_addr, eng_done,
        input  cmd_rdy, eng_vld, eng_smc_strb, eng_byte_strb, eng_brst,
               eng_gr_base_addr, eng_smc_id, eng_ur_id, eng_ur_addr
    );

endinterface

// File: rtl/ldb_cmd_queue_sync_fifo.sv
// Generic synchronous FIFO with flush; pointers carry a wrap bit so full and
// empty fall out of a pointer compare. Flush discards a same-cycle push.
module ldb_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count   = wptr - rptr;
    assign rdata   = mem[rptr[AW-1:0]];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;

    // Pointer update; flush collapses the read pointer onto the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            rptr <= wptr;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    // Storage write; contents need no reset because empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ldb_cmd_queue.sv
// LDB command queue: buffers dispatcher commands, drops illegal ones and
// issues one command at a time to the load engine, waiting for its done.
// Optional macro LDB_Q_PERF_EN adds perf_issued / perf_busy_cyc counters.
module ldb_cmd_queue import ldb_pkg::*; #(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned PARAM_SMC_CNT = LDB_SMC_CNT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ldb_cmd_queue_if.slave         bus,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   busy,
    output logic                   err_drop,
    output logic [DROP_CNT_W-1:0]  drop_cnt
`ifdef LDB_Q_PERF_EN
    ,
    output logic [31:0]            perf_issued,
    output logic [31:0]            perf_busy_cyc
`endif
);
    localparam int unsigned SMC_ID_W = $clog2(PARAM_SMC_CNT);

    ldb_cmd_t            cmd_in;
    ldb_cmd_t            head;
    ldb_cmd_t            eng_q;
    logic                eng_vld_q;
    logic [SMC_ID_W-1:0] smc_id_in;
    logic                accept;
    logic                legal;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    ldb_state_t          state;
    ldb_state_t          state_nxt;

    assign smc_id_in = bus.cmd_smc_id;

    // Pack the dispatcher fields into one queue record.
    always_comb begin
        cmd_in              = '0;
        cmd_in.smc_strb     = bus.cmd_smc_strb;
        cmd_in.byte_strb    = bus.cmd_byte_strb;
        cmd_in.brst         = bus.cmd_brst;
        cmd_in.gr_base_addr = bus.cmd_gr_base_addr;
        cmd_in.smc_id       = smc_id_in;
        cmd_in.ur_id        = bus.cmd_ur_id;
        cmd_in.ur_addr      = bus.cmd_ur_addr;
    end

    assign bus.cmd_rdy = !full;
    assign accept      = bus.cmd_vld && !full;
    assign legal       = cmd_legal(cmd_in);
    assign push        = accept && legal;
    assign busy        = (state != IDLE) || (q_count != '0);

    ldb_sync_fifo #(
        .WIDTH ($bits(ldb_cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (cmd_in),
        .pop   (pop),
        .rdata (head),
        .flush (flush),
        .full  (full),
        .empty (empty),
        .count (q_count)
    );

    // Issue FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Issue FSM next state; done must be seen high then low before re-issuing.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: if (bus.eng_done)  state_nxt = DRAIN;
            DRAIN:     if (!bus.eng_done) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Issue register: one-cycle valid pulse, fields held until the next issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_vld_q <= 1'b0;
            eng_q     <= '0;
        end else begin
            eng_vld_q <= pop;
            if (pop) eng_q <= head;
        end
    end

    assign bus.eng_vld          = eng_vld_q;
    assign bus.eng_smc_strb     = eng_q.smc_strb;
    assign bus.eng_byte_strb    = eng_q.byte_strb;
    assign bus.eng_brst         = eng_q.brst;
    assign bus.eng_gr_base_addr = eng_q.gr_base_addr;
    assign bus.eng_smc_id       = eng_q.smc_id;
    assign bus.eng_ur_id        = eng_q.ur_id;
    assign bus.eng_ur_addr      = eng_q.ur_addr;

    // Drop bookkeeping: sticky error flag and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_drop <= 1'b0;
            drop_cnt <= '0;
        end else if (accept && !legal) begin
            err_drop <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 8'd1;
        end
    end

`ifdef LDB_Q_PERF_EN
    // Wrapping performance counters: issues and non-idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued   <= '0;
            perf_busy_cyc <= '0;
        end else begin
            if (pop)           perf_issued   <= perf_issued + 32'd1;
            if (state != IDLE) perf_busy_cyc <= perf_busy_cyc + 32'd1;
        end
    end
`endif

endmodule
